// File: rtl/inv_subbytes_seq.sv
// Sequential AES InvSubBytes stage: accepts one 128-bit state over valid/ready,
// substitutes BPC bytes per cycle through shared inverse S-box logic, then holds the result.
module inv_subbytes_seq #(
    parameter int BPC = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NCYC = 16 / BPC;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int CB   = 8 * BPC;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [127:0]    r_work;
    logic            r_out_valid;
    logic            r_busy;
    logic [CB-1:0]   w_chunk_in;
    logic [CB-1:0]   w_chunk_out;

    // GF(2^8) arithmetic modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = gf_xtime(aa);
        end
        return p;
    endfunction

    // x^254 = x^-1 for x != 0 and yields 0 for x == 0, so no special case is needed.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        return gf_mul(x127, x127);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    assign w_chunk_in = r_work[r_cnt * CB +: CB];

    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        w_chunk_out = '0;
        for (int i = 0; i < BPC; i++) begin
            w_chunk_out[8*i +: 8] = inv_sbox(w_chunk_in[8*i +: 8]);
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            // NOTE: the work register is reset too, so out_state never carries X after reset.
            r_work      <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work  <= in_state;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_work[r_cnt * CB +: CB] <= w_chunk_out;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt       <= '0;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Ready is held low while reset is asserted and rises as soon as reset releases.
    assign in_ready  = (r_state == S_IDLE) & rst_n;
    assign out_valid = r_out_valid;
    assign out_state = r_work;
    assign busy      = r_busy;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Scoreboard bench for inv_subbytes_seq: directed FIPS-197 vectors on BPC=4 plus
// random states on BPC=1/4/16 against an independently derived inverse S-box table.
`timescale 1ns/1ps
module tb_inv_subbytes_seq;

    localparam int NU = 3;
    localparam int N_RAND = 1000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid  [NU];
    logic         in_ready  [NU];
    logic [127:0] in_state  [NU];
    logic         out_valid [NU];
    logic         out_ready [NU];
    logic [127:0] out_state [NU];
    logic         busy      [NU];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        inv_subbytes_seq #(.BPC(g == 0 ? 1 : (g == 1 ? 4 : 16))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    typedef struct {
        logic [127:0] data;
        int           acc;
    } exp_t;

    exp_t         q0[$], q1[$], q2[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    logic [7:0]   inv_tab [256];
    bit           pending [NU];
    logic [127:0] held    [NU];
    bit           rand_done [NU];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ncyc(input int u);
        case (u)
            0:       return 16;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic void q_push(input int u, input logic [127:0] d, input int acc);
        exp_t e;
        e.data = d;
        e.acc  = acc;
        case (u)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int q_size(input int u);
        case (u)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t q_pop(input int u);
        case (u)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void q_drop_last(input int u);
        exp_t e;
        case (u)
            0:       e = q0.pop_back();
            1:       e = q1.pop_back();
            default: e = q2.pop_back();
        endcase
    endfunction

    // Reference built from the forward S-box: polynomial-division GF multiply,
    // brute-force inverse, forward affine with 0x63, then table inversion.
    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [127:0] ref_inv(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int u, input logic [127:0] s, input logic [127:0] e);
        int t;
        t = 0;
        in_valid[u] = 1'b1;
        in_state[u] = s;
        while (1) begin
            @(negedge clk);
            if (in_ready[u]) begin
                q_push(u, e, cyc + 1);
                break;
            end
            t++;
            if (t > 500) begin
                check($sformatf("u%0d_accept_timeout", u), in_ready[u], 1'b1);
                in_valid[u] = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        in_state[u] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int u = 0; u < NU; u++) begin
                if (!rst_n || !out_valid[u]) begin
                    pending[u] = 1'b0;
                end else begin
                    if (!pending[u]) begin
                        if (q_size(u) == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL u%0d_spurious: out_valid with nothing expected, got %0h", u, out_state[u]);
                        end else begin
                            e = q_pop(u);
                            check($sformatf("u%0d_data", u), out_state[u], e.data);
                            check($sformatf("u%0d_latency", u), 128'(cyc - e.acc), 128'(ncyc(u)));
                        end
                        pending[u] = 1'b1;
                        held[u]    = out_state[u];
                    end else begin
                        check($sformatf("u%0d_hold", u), out_state[u], held[u]);
                    end
                    if (out_ready[u]) pending[u] = 1'b0;
                end
            end
        end
    endtask

    task automatic run_random(input int u);
        logic [127:0] s;
        for (int n = 0; n < N_RAND; n++) begin
            s = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(u, s, ref_inv(s));
            repeat ($urandom_range(0, 2)) tick(1);
        end
        rand_done[u] = 1'b1;
    endtask

    task automatic toggle_ready();
        while (!(rand_done[0] && rand_done[1] && rand_done[2])) begin
            @(posedge clk);
            #1;
            for (int u = 0; u < NU; u++) out_ready[u] = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] s;
        int t;

        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++) if (tb_gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
            inv_tab[s] = 8'(x);
        end

        for (int u = 0; u < NU; u++) begin
            in_valid[u]  = 1'b0;
            in_state[u]  = '0;
            out_ready[u] = 1'b1;
            pending[u]   = 1'b0;
            rand_done[u] = 1'b0;
        end
        fork
            monitor();
        join_none

        // T1: reset held with random inputs
        rst_n = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            for (int u = 0; u < NU; u++) begin
                in_valid[u]  = 1'($urandom_range(0, 1));
                out_ready[u] = 1'($urandom_range(0, 1));
                in_state[u]  = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            @(negedge clk);
            for (int u = 0; u < NU; u++) begin
                check($sformatf("t1_u%0d_out_valid", u), out_valid[u], 1'b0);
                check($sformatf("t1_u%0d_in_ready", u), in_ready[u], 1'b0);
                check($sformatf("t1_u%0d_out_state", u), out_state[u], '0);
                check($sformatf("t1_u%0d_busy", u), busy[u], 1'b0);
            end
        end
        for (int u = 0; u < NU; u++) begin
            in_valid[u]  = 1'b0;
            out_ready[u] = 1'b1;
        end
        rst_n = 1'b1;
        #1;
        for (int u = 0; u < NU; u++) check($sformatf("t1_u%0d_ready_after", u), in_ready[u], 1'b1);
        @(posedge clk);
        #1;

        // T2/T3: directed vectors on BPC=4
        send(1, 128'h0, {16{8'h52}});
        tick(8);
        send(1, 128'h76abd7fe_2b670130_c56f6bf2_7b777c63, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
        tick(8);
        send(1, 128'h00000000_00000000_00000000_00000116, 128'h52525252_52525252_52525252_525209ff);
        tick(8);

        // T4: backpressure, second request must not be captured
        out_ready[1] = 1'b0;
        send(1, {16{8'h7c}}, {16{8'h01}});
        t = 0;
        while (!out_valid[1] && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t4_out_valid_rise", out_valid[1], 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid[1] = 1'b1;
            in_state[1] = 128'hdeadbeef_01234567_89abcdef_cafef00d;
            @(negedge clk);
            check("t4_in_ready_low", in_ready[1], 1'b0);
            check("t4_out_valid_held", out_valid[1], 1'b1);
        end
        @(posedge clk);
        #1;
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        check("t4_idle_ready", in_ready[1], 1'b1);
        check("t4_idle_out_valid", out_valid[1], 1'b0);
        tick(8);

        // T5: reset at cnt==2 discards the block
        send(1, {16{8'h63}}, {16{8'h00}});
        tick(2);
        check("t5_busy", busy[1], 1'b1);
        check("t5_in_ready_busy", in_ready[1], 1'b0);
        #2;
        rst_n = 1'b0;
        q_drop_last(1);
        #1;
        check("t5_rst_out_valid", out_valid[1], 1'b0);
        check("t5_rst_busy", busy[1], 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_ready_after", in_ready[1], 1'b1);
        tick(6);
        send(1, 128'h76abd7fe_2b670130_c56f6bf2_7b777c63, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
        tick(8);

        // T6: random states on all three widths with random backpressure
        fork
            run_random(0);
            run_random(1);
            run_random(2);
            toggle_ready();
        join
        for (int u = 0; u < NU; u++) out_ready[u] = 1'b1;
        t = 0;
        while ((q_size(0) + q_size(1) + q_size(2)) != 0 && t < 100) begin
            tick(1);
            t++;
        end
        tick(4);
        for (int u = 0; u < NU; u++) check($sformatf("u%0d_undelivered", u), 128'(q_size(u)), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
